// File: rtl/block_copy_master_if.sv
// Avalon-MM master/slave bus bundle for the block copy engine.
interface block_copy_master_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) ();
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address,
        output chipselect,
        output read,
        output write,
        output byteenable,
        output writedata,
        output clken,
        input  readdata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read,
        input  write,
        input  byteenable,
        input  writedata,
        input  clken,
        output readdata,
        output waitrequest
    );
endinterface

// File: rtl/block_copy_master.sv
// Word-by-word memory block copy engine: read one word, write it, repeat.
module block_copy_master #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    block_copy_master_if.master bus
);
    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [DATA_W-1:0] buffer;
    logic [ADDR_W-1:0] address_q;
    logic              read_q;
    logic              write_q;
    logic              cs_q;
    logic              busy_q;
    logic              done_q;

    // Word index after the current write is accepted.
    logic [LEN_W-1:0]  idx_next_c;
    assign idx_next_c = idx + LEN_W'(1);

    // Sequencer: all bus strobes and status flags are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            idx       <= '0;
            buffer    <= '0;
            address_q <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            cs_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (length == '0) begin
                            // Empty copy: report completion without touching the bus.
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= RD;
                            src_q     <= src_addr;
                            dst_q     <= dst_addr;
                            len_q     <= length;
                            idx       <= '0;
                            address_q <= src_addr;
                            read_q    <= 1'b1;
                            cs_q      <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                end

                RD: begin
                    // Command held unchanged until the slave stops stalling.
                    if (!bus.waitrequest) begin
                        state  <= RWAIT;
                        read_q <= 1'b0;
                        cs_q   <= 1'b0;
                    end
                end

                RWAIT: begin
                    // Read latency is one cycle, so data is valid now.
                    state     <= WR;
                    buffer    <= bus.readdata;
                    address_q <= dst_q + ADDR_W'(idx);
                    write_q   <= 1'b1;
                    cs_q      <= 1'b1;
                end

                WR: begin
                    if (!bus.waitrequest) begin
                        write_q <= 1'b0;
                        idx     <= idx_next_c;
                        if (idx_next_c == len_q) begin
                            state  <= DONE;
                            cs_q   <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state     <= RD;
                            address_q <= src_q + ADDR_W'(idx_next_c);
                            read_q    <= 1'b1;
                            cs_q      <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    cs_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bus from the registered command state.
    assign bus.address    = address_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.chipselect = cs_q;
    assign bus.writedata  = buffer;
    assign bus.byteenable = {BE_W{1'b1}};
    assign bus.clken      = 1'b1;

    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_block_copy_master.sv
// Self-checking bench: memory slave model, vector table, reset/restart sequences, random copies.
module tb_block_copy_master;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 13;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;

    block_copy_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    block_copy_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Slave memory and the reference image of what it should hold.
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    int  rd_stall_left = 0;
    int  wr_stall_left = 0;
    bit  rand_mode     = 1'b0;
    bit  rand_bit      = 1'b0;
    int  edge_cnt      = 0;
    int  stall_cnt     = 0;
    int  done_cnt      = 0;
    int  proto_err     = 0;
    logic [ADDR_W-1:0] rd_log [$];
    logic [ADDR_W-1:0] wr_log [$];

    logic              hold_prev = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_rd;
    logic              prev_wr;
    logic [DATA_W-1:0] prev_wd;

    assign bus.waitrequest = (bus.read  && (rand_mode ? rand_bit : (rd_stall_left > 0))) ||
                             (bus.write && (rand_mode ? rand_bit : (wr_stall_left > 0)));

    always @(negedge clk) rand_bit = ($urandom_range(0, 2) == 0);

    // Memory slave plus protocol observer, acting on pre-edge values.
    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
        if (bus.read && bus.write) proto_err = proto_err + 1;
        if (bus.chipselect !== (bus.read | bus.write)) proto_err = proto_err + 1;
        if (hold_prev && (bus.address !== prev_addr || bus.read !== prev_rd ||
                          bus.write !== prev_wr || (prev_wr && bus.writedata !== prev_wd)))
            proto_err = proto_err + 1;
        hold_prev = (bus.read | bus.write) & bus.waitrequest & ~reset;
        prev_addr = bus.address;
        prev_rd   = bus.read;
        prev_wr   = bus.write;
        prev_wd   = bus.writedata;
        if (bus.read) begin
            if (bus.waitrequest) begin
                stall_cnt = stall_cnt + 1;
                if (rd_stall_left > 0) rd_stall_left = rd_stall_left - 1;
            end else begin
                bus.readdata <= mem[bus.address];
                rd_log.push_back(bus.address);
            end
        end
        if (bus.write) begin
            if (bus.waitrequest) begin
                stall_cnt = stall_cnt + 1;
                if (wr_stall_left > 0) wr_stall_left = wr_stall_left - 1;
            end else begin
                mem[bus.address] = bus.writedata;
                wr_log.push_back(bus.address);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_read"},       64'(bus.read), 64'd0);
        check({tag, "_write"},      64'(bus.write), 64'd0);
        check({tag, "_cs"},         64'(bus.chipselect), 64'd0);
        check({tag, "_busy"},       64'(busy), 64'd0);
        check({tag, "_done"},       64'(done), 64'd0);
        check({tag, "_address"},    64'(bus.address), 64'd0);
        check({tag, "_writedata"},  64'(bus.writedata), 64'd0);
        check({tag, "_byteenable"}, 64'(bus.byteenable), 64'((1 << BE_W) - 1));
        check({tag, "_clken"},      64'(bus.clken), 64'd1);
    endtask

    // One copy from start to a few cycles past done; exp_done < 0 derives it from observed stalls.
    task automatic run_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input int l,
                            input int srd, input int swr, input bit rmode,
                            input int exp_done, input bit pulse_mid, input string tag);
        logic [ADDR_W-1:0] exp_rd [$];
        logic [ADDR_W-1:0] exp_wr [$];
        int base, c, done_c, busy_err, seq_err, mem_err, want;
        bit seen;
        for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = mem[k];
        for (int k = 0; k < l; k++) begin
            logic [ADDR_W-1:0] sa, da;
            sa = s + ADDR_W'(k);
            da = d + ADDR_W'(k);
            exp_rd.push_back(sa);
            exp_wr.push_back(da);
            ref_mem[da] = ref_mem[sa];
        end
        @(negedge clk);
        rd_log.delete();
        wr_log.delete();
        done_cnt = 0; stall_cnt = 0; proto_err = 0;
        rd_stall_left = srd; wr_stall_left = swr; rand_mode = rmode;
        src_addr = s; dst_addr = d; length = LEN_W'(l); start = 1'b1;
        base = edge_cnt;
        @(negedge clk);
        start = 1'b0;
        src_addr = ADDR_W'($urandom); dst_addr = ADDR_W'($urandom); length = LEN_W'($urandom_range(1, 9));
        busy_err = 0; done_c = -1; seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            c = edge_cnt - base;
            if (done) begin
                done_c = c;
                seen = 1'b1;
                if (busy !== 1'b0) busy_err++;
            end else begin
                if (busy !== (l != 0)) busy_err++;
                if (pulse_mid && c == 2) start = 1'b1;
                else start = 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) $display("FAIL %s_timeout: got no done expected done", tag);
        repeat (3) @(negedge clk);
        rand_mode = 1'b0;
        want = (exp_done < 0) ? (3 * l + 1 + stall_cnt) : exp_done;
        check({tag, "_done_cycle"}, 64'(done_c), 64'(want));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_profile"}, 64'(busy_err), 64'd0);
        check({tag, "_protocol"}, 64'(proto_err), 64'd0);
        seq_err = 0;
        if (rd_log.size() != exp_rd.size() || wr_log.size() != exp_wr.size()) seq_err++;
        else begin
            foreach (exp_rd[k]) if (rd_log[k] !== exp_rd[k]) seq_err++;
            foreach (exp_wr[k]) if (wr_log[k] !== exp_wr[k]) seq_err++;
        end
        check({tag, "_addr_seq"}, 64'(seq_err), 64'd0);
        mem_err = 0;
        for (int k = 0; k < int'(DEPTH); k++) if (mem[k] !== ref_mem[k]) mem_err++;
        check({tag, "_mem"}, 64'(mem_err), 64'd0);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        int                len;
        int                srd;
        int                swr;
        int                exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [DATA_W-1:0] old3;
        bit reached;
        vecs[0] = '{12'h010, 12'h100, 4, 0, 0, 13};
        vecs[1] = '{12'h050, 12'h060, 0, 0, 0, 1};
        vecs[2] = '{12'hFFE, 12'h000, 4, 0, 0, 13};
        vecs[3] = '{12'h010, 12'h100, 4, 3, 2, 18};
        vecs[4] = '{12'h020, 12'h022, 5, 0, 0, 16};
        vecs[5] = '{12'h7FF, 12'hFFF, 3, 0, 0, 10};

        for (int k = 0; k < int'(DEPTH); k++) mem[k] = $urandom;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        foreach (vecs[v])
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].srd, vecs[v].swr,
                     1'b0, vecs[v].exp_done, 1'b0, $sformatf("vec%0d", v));

        // Restart request while busy must be ignored.
        run_copy(12'h300, 12'h380, 4, 0, 0, 1'b0, 13, 1'b1, "restart");

        // Reset in the middle of the third write aborts the copy.
        old3 = mem[12'h503];
        @(negedge clk);
        done_cnt = 0; rd_log.delete(); wr_log.delete();
        src_addr = 12'h400; dst_addr = 12'h500; length = 13'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
            if (bus.write && wr_log.size() == 2) reached = 1'b1;
            else @(negedge clk);
        end
        check("abort_reached_wr2", 64'(reached), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_busy_low", 64'(busy), 64'd0);
        check("abort_word0", 64'(mem[12'h500]), 64'(mem[12'h400]));
        check("abort_word1", 64'(mem[12'h501]), 64'(mem[12'h401]));
        check("abort_word3_untouched", 64'(mem[12'h503]), 64'(old3));
        run_copy(12'h600, 12'h700, 1, 0, 0, 1'b0, 4, 1'b0, "after_abort");

        // Random copies with random stalls and stray start pulses.
        for (int r = 0; r < 25; r++)
            run_copy(ADDR_W'($urandom), ADDR_W'($urandom), $urandom_range(0, 10), 0, 0,
                     1'b1, -1, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
